// File: rtl/mem_bist_pkg.sv
// Shared types and constants for the memory BIST controller.
package mem_bist_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [DATA_W-1:0] DEFAULT_SEED = 32'hA5A5_0000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR0  = 3'd1,
    RD0  = 3'd2,
    WR1  = 3'd3,
    RD1  = 3'd4,
    DONE = 3'd5
  } bist_state_t;

  function automatic logic is_wr(input bist_state_t s);
    return (s == WR0) || (s == WR1);
  endfunction

  function automatic logic is_rd(input bist_state_t s);
    return (s == RD0) || (s == RD1);
  endfunction

  // Second pass writes and checks the complemented pattern.
  function automatic logic is_inv(input bist_state_t s);
    return (s == WR1) || (s == RD1);
  endfunction

endpackage

// File: rtl/mem_bist_ctrl_pattern_gen.sv
// Test pattern: address XOR seed, complemented on the second pass.
module bist_pattern_gen
  import mem_bist_pkg::*;
#(
  parameter logic [DATA_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              inv,
  output logic [DATA_W-1:0] pattern
);

  assign pattern = (DATA_W'(addr) ^ SEED) ^ {DATA_W{inv}};

endmodule

// File: rtl/mem_bist_ctrl.sv
// Two-pass write/read-back memory BIST; stops at the first mismatch and
// records its address, expected and actual word.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int                DEPTH = 16,
  parameter logic [DATA_W-1:0] SEED  = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  output logic              write_enable,
  output logic              read_enable,
  input  logic [DATA_W-1:0] read_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_act
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  bist_state_t       state, nstate;
  logic [ADDR_W-1:0] ncnt;
  logic [DATA_W-1:0] pat_cur, pat_nxt;
  logic              accept, mism, fin;

  // The address register doubles as the word counter; it is 0 outside tests.
  bist_pattern_gen #(.SEED(SEED)) u_pat_cur (
    .addr   (address),
    .inv    (is_inv(state)),
    .pattern(pat_cur)
  );

  bist_pattern_gen #(.SEED(SEED)) u_pat_nxt (
    .addr   (ncnt),
    .inv    (is_inv(nstate)),
    .pattern(pat_nxt)
  );

  always_comb begin
    nstate = state;
    ncnt   = address;
    accept = 1'b0;
    mism   = 1'b0;
    fin    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          nstate = WR0;
          ncnt   = '0;
          accept = 1'b1;
        end
      end
      default: begin
        if (is_rd(state) && (read_data != pat_cur)) begin
          mism   = 1'b1;
          nstate = DONE;
          ncnt   = '0;
        end else if (address == LAST) begin
          ncnt = '0;
          case (state)
            WR0:     nstate = RD0;
            RD0:     nstate = WR1;
            WR1:     nstate = RD1;
            default: begin
              nstate = DONE;
              fin    = 1'b1;
            end
          endcase
        end else begin
          ncnt = address + ADDR_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  // Outputs are registered from the next-state view so they line up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address      <= '0;
      write_data   <= '0;
      write_enable <= 1'b0;
      read_enable  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      address      <= ncnt;
      write_data   <= is_wr(nstate) ? pat_nxt : '0;
      write_enable <= is_wr(nstate);
      read_enable  <= is_rd(nstate);
      busy         <= is_wr(nstate) || is_rd(nstate);
      done         <= (nstate == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_act  <= '0;
    end else if (accept) begin
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_act  <= '0;
    end else if (mism) begin
      fail_addr <= address;
      fail_exp  <= pat_cur;
      fail_act  <= read_data;
    end else if (fin) begin
      pass <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl with a 16-word memory and injectable faults.
module tb_mem_bist_ctrl;

  localparam int          DEPTH = 16;
  localparam logic [31:0] SEED  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [31:0] address, write_data, read_data;
  logic        write_enable, read_enable, busy, done, pass;
  logic [31:0] fail_addr, fail_exp, fail_act;

  int errors = 0;
  int checks = 0;
  int fault  = 0;

  logic [31:0] mem [DEPTH];

  always #5 clk = ~clk;

  mem_bist_ctrl #(.DEPTH(DEPTH), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .address(address), .write_data(write_data),
    .write_enable(write_enable), .read_enable(read_enable),
    .read_data(read_data), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_act(fail_act)
  );

  always @(posedge clk)
    if (write_enable) mem[address[3:0]] <= write_data;

  // Combinational read with optional faults on a single cell.
  always_comb begin
    read_data = '0;
    if (read_enable) begin
      read_data = mem[address[3:0]];
      if (fault == 1 && address == 32'd5) read_data[0]  = 1'b0;
      if (fault == 2 && address == 32'd9) read_data[31] = 1'b1;
    end
  end

  typedef struct {
    int          fault;
    bit          extra;
    int          exp_cyc;
    bit          exp_pass;
    logic [31:0] fa, fe, fx;
  } vec_t;

  vec_t vt[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int a, input int ph);
    logic [31:0] p;
    p = 32'(a) ^ SEED;
    if (ph >= 2) p = ~p;
    return p;
  endfunction

  task automatic run_vec(input vec_t v);
    int cyc, bad, ph, a;
    fault = v.fault;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("clear_on_accept", {26'd0, done, pass, |fail_addr, |fail_exp, |fail_act, busy}, 32'd1);
    cyc = 0; bad = 0;
    while (busy && cyc < 200) begin
      ph = cyc / DEPTH;
      a  = cyc % DEPTH;
      if (address !== 32'(a)) bad++;
      if (write_enable !== (ph == 0 || ph == 2)) bad++;
      if (read_enable  !== (ph == 1 || ph == 3)) bad++;
      if (write_enable && write_data !== pat(a, ph)) bad++;
      cyc++;
      start = v.extra && (cyc == 3 || cyc == 20);
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_cycles", 32'(cyc), 32'(v.exp_cyc));
    check("addr_seq_errs", 32'(bad), 32'd0);
    check("done", {31'd0, done}, 32'd1);
    check("pass", {31'd0, pass}, {31'd0, v.exp_pass});
    check("fail_addr", fail_addr, v.fa);
    check("fail_exp", fail_exp, v.fe);
    check("fail_act", fail_act, v.fx);
    repeat (3) @(negedge clk);
    check("quiet_after_done", {29'd0, write_enable, read_enable, busy} | address, 32'd0);
  endtask

  initial begin
    vt[0] = '{0, 1'b0, 64, 1'b1, 32'h0, 32'h0, 32'h0};
    vt[1] = '{1, 1'b0, 22, 1'b0, 32'd5, 32'hA5A5_0005, 32'hA5A5_0004};
    vt[2] = '{0, 1'b1, 64, 1'b1, 32'h0, 32'h0, 32'h0};
    vt[3] = '{2, 1'b0, 58, 1'b0, 32'd9, 32'h5A5A_FFF6, 32'hDA5A_FFF6};
    vt[4] = '{0, 1'b0, 64, 1'b1, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    rst_n = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outs", address | write_data | fail_addr | fail_exp | fail_act |
          {27'd0, write_enable, read_enable, busy, done, pass}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_without_start", {29'd0, busy, done, write_enable | read_enable}, 32'd0);

    // Reset in the middle of a test.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (30) @(negedge clk);
    check("midtest_busy", {31'd0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midtest_reset_outs", address | write_data |
          {27'd0, write_enable, read_enable, busy, done, pass}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("stays_idle", {29'd0, busy, done, write_enable | read_enable} | address, 32'd0);

    for (int i = 0; i < 5; i++) run_vec(vt[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bist_ctrl.md
MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of words tested, addresses 0..DEPTH-1, with DEPTH >= 2.
REQ-002 SHALL have parameter SEED, default 32'hA5A5_0000, meaning the XOR base of the test pattern.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to begin a test.
REQ-006 SHALL have port address, output, 32 bits: memory word address to DataMemory.
REQ-007 SHALL have port write_data, output, 32 bits: memory write data.
REQ-008 SHALL have port write_enable, output, 1 bit: memory write strobe.
REQ-009 SHALL have port read_enable, output, 1 bit: memory read strobe.
REQ-010 SHALL have port read_data, input, 32 bits: memory read data, combinational from address and read_enable.
REQ-011 SHALL have port busy, output, 1 bit: test in progress.
REQ-012 SHALL have port done, output, 1 bit: test finished; held until the next accepted start.
REQ-013 SHALL have port pass, output, 1 bit: valid while done is high; 1 means no mismatch.
REQ-014 SHALL have port fail_addr, output, 32 bits: address of the first mismatch.
REQ-015 SHALL have port fail_exp, output, 32 bits: expected word at the first mismatch.
REQ-016 SHALL have port fail_act, output, 32 bits: actual word at the first mismatch.

Function
REQ-017 SHALL implement an FSM with states IDLE, WR0, RD0, WR1, RD1 and DONE.
REQ-018 SHALL define pattern P(a) = a XOR SEED for pass 0 and ~P(a) for pass 1.
REQ-019 SHALL, in IDLE or DONE with start=1 at an edge, enter WR0 with the address counter at 0, clear done, pass and the fail_* registers, and set busy.
REQ-020 SHALL ignore start while busy=1.
REQ-021 SHALL, in WR0/WR1, drive write_enable=1, read_enable=0, address=counter and write_data=pattern(counter), one word per cycle.
REQ-022 SHALL, in RD0/RD1, drive read_enable=1, write_enable=0 and address=counter, and compare read_data against pattern(counter) at the closing edge.
REQ-023 SHALL increment the counter each cycle in WR*/RD* states; at DEPTH-1, reset it to 0 and advance WR0->RD0->WR1->RD1->DONE.
REQ-024 SHALL, on the first mismatch, capture fail_addr, fail_exp and fail_act, go to DONE with pass=0, and perform no further accesses.
REQ-025 SHALL set done=1 and pass=1 after RD1 completes with no mismatch, exactly 4*DEPTH cycles after start is accepted.
REQ-026 SHALL hold write_enable=read_enable=0 and address=0 in IDLE and DONE, and SHALL never assert both strobes together.
REQ-027 SHALL drive all outputs from registers; the only combinational path is read_data into the compare.

Reset
REQ-028 SHALL, on rst_n low at any time including mid-test, go immediately to IDLE with address, write_data, both strobes, busy, done, pass and fail_* = 0.
REQ-029 SHALL, after rst_n rises, leave IDLE only on start.

Structure
REQ-030 SHALL place the state enum (bist_state_t), the DATA_W=32/ADDR_W=32 constants and the default SEED in package mem_bist_pkg.
REQ-031 SHALL contain one natural sub-module, bist_pattern_gen (address, pass bit -> pattern word, combinational), shared by the write and compare paths.

Verification (DEPTH=16, SEED=32'hA5A5_0000, real DataMemory)
REQ-032 Fault-free memory, start pulse: must see busy for 64 cycles, then done=1, pass=1, with the address sequence 0..15 repeated four times.
REQ-033 Memory model forcing read_data[0]=0 at address 5: must end in RD0 with fail_addr=5, fail_exp=32'hA5A5_0005 and fail_act=32'hA5A5_0004; done=1, pass=0, no strobes afterwards.
REQ-034 Stuck-at-1 bit 31 at address 9: must pass RD0 and fail in RD1 with fail_exp=32'h5A5A_FFF6 and fail_act=32'hDA5A_FFF6.
REQ-035 Start pulses at cycles 3 and 20 after acceptance: must be ignored, with completion still at 64 cycles.
REQ-036 rst_n low at cycle 30 of a test: all outputs must go to 0 immediately, the FSM must stay in IDLE; a later start must complete with pass=1.
REQ-037 Second start while done=1: must clear done/pass/fail_* on the accepting edge and rerun the full 64-cycle test.
